// File: rtl/seq_step_counter_pkg.sv
// seq_step_pkg: shared types and helpers for the timing-step sequencer.
//   state_t     : run/halt FSM encoding (ST_HALT, ST_RUN)
//   WRAP        : WRAP_MODE value that rolls the last step over to T0
//   SATURATE    : WRAP_MODE value that parks the count on the last step
//   clog2_min1  : index width for N steps, never less than 1 bit
package seq_step_pkg;

  typedef enum logic {
    ST_HALT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int WRAP     = 1;
  localparam int SATURATE = 0;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seq_step_counter_if.sv
// seq_step_counter_if: control and status bundle of the step sequencer.
//   Parameter NUM_STEPS sets the widths of t, count and load_val.
//   master modport: control unit side (drives clr/inc/load/load_val/start/stop)
//   slave modport : sequencer side (drives t/count/running/last/wrap[/err])
//   Optional macro SEQ_STEP_COUNTER_ERR_EN adds the sticky err status bit.
interface seq_step_counter_if
  import seq_step_pkg::*;
#(
  parameter int NUM_STEPS = 16
);
  localparam int CNT_W = clog2_min1(NUM_STEPS);

  logic                 clr;
  logic                 inc;
  logic                 load;
  logic [CNT_W-1:0]     load_val;
  logic                 start;
  logic                 stop;
  logic [NUM_STEPS-1:0] t;
  logic [CNT_W-1:0]     count;
  logic                 running;
  logic                 last;
  logic                 wrap;
`ifdef SEQ_STEP_COUNTER_ERR_EN
  logic                 err;

  modport master (
    output clr, inc, load, load_val, start, stop,
    input  t, count, running, last, wrap, err
  );
  modport slave (
    input  clr, inc, load, load_val, start, stop,
    output t, count, running, last, wrap, err
  );
`else
  modport master (
    output clr, inc, load, load_val, start, stop,
    input  t, count, running, last, wrap
  );
  modport slave (
    input  clr, inc, load, load_val, start, stop,
    output t, count, running, last, wrap
  );
`endif

endinterface

// File: rtl/seq_step_counter_onehot_decoder.sv
// onehot_decoder: combinational step index to one-hot conversion.
//   idx    in  W  binary index
//   onehot out N  onehot[i] = (idx == i); all zero for idx >= N
module onehot_decoder
  import seq_step_pkg::*;
#(
  parameter int N = 16,
  parameter int W = clog2_min1(N)
) (
  input  logic [W-1:0] idx,
  output logic [N-1:0] onehot
);

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_bit
      assign onehot[gi] = (idx == W'(gi));
    end
  endgenerate

endmodule

// File: rtl/seq_step_counter.sv
// seq_step_counter: parametrised one-hot timing-step sequencer.
//   clk   in  system clock, all state on posedge
//   rst_n in  synchronous active-low reset
//   bus   seq_step_counter_if.slave:
//         clr/inc/load/load_val/start/stop in; t/count/running/last/wrap out
// Parameters: NUM_STEPS (2..64), WRAP_MODE (WRAP/SATURATE), START_RUNNING.
// Optional macro SEQ_STEP_COUNTER_ERR_EN: adds sticky err output, set by an
// out-of-range load or a one-hot violation on t, cleared by rst_n or clr.
module seq_step_counter
  import seq_step_pkg::*;
#(
  parameter int NUM_STEPS     = 16,
  parameter int WRAP_MODE     = 1,
  parameter int START_RUNNING = 1
) (
  input logic                clk,
  input logic                rst_n,
  seq_step_counter_if.slave  bus
);

  localparam int               CNT_W    = clog2_min1(NUM_STEPS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_STEPS - 1);

  state_t           state_reg;
  state_t           state_next;
  logic [CNT_W-1:0] count_reg;
  logic             running_reg;
  logic             wrap_reg;
  // Remembers that the saturating inc has already pulsed wrap, so that
  // repeated incs at the last step stay silent until the count is moved.
  logic             sat_hit_reg;
  logic             load_in_range;
  logic             inc_en;
  logic [NUM_STEPS-1:0] t_dec;

  assign load_in_range = (int'(bus.load_val) < NUM_STEPS);
  // The state register is sampled before the update, so an inc that
  // coincides with stop still applies on that edge.
  assign inc_en        = bus.inc && (state_reg == ST_RUN);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_HALT: if (bus.start && !bus.stop) state_next = ST_RUN;
      ST_RUN:  if (bus.stop)               state_next = ST_HALT;
      default: state_next = ST_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= (START_RUNNING != 0) ? ST_RUN : ST_HALT;
      running_reg <= (START_RUNNING != 0);
      count_reg   <= '0;
      wrap_reg    <= 1'b0;
      sat_hit_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      // Decoding the next state keeps running aligned with the state register.
      running_reg <= (state_next == ST_RUN);
      wrap_reg    <= 1'b0;
      if (bus.clr) begin
        count_reg   <= '0;
        sat_hit_reg <= 1'b0;
      end else if (bus.load) begin
        if (load_in_range) begin
          count_reg   <= bus.load_val;
          sat_hit_reg <= 1'b0;
        end
      end else if (inc_en) begin
        if (count_reg != LAST_IDX) begin
          count_reg <= count_reg + 1'b1;
        end else if (WRAP_MODE == WRAP) begin
          count_reg <= '0;
          wrap_reg  <= 1'b1;
        end else begin
          wrap_reg    <= !sat_hit_reg;
          sat_hit_reg <= 1'b1;
        end
      end
    end
  end

  onehot_decoder #(
    .N (NUM_STEPS),
    .W (CNT_W)
  ) u_dec (
    .idx    (count_reg),
    .onehot (t_dec)
  );

  assign bus.t       = t_dec;
  assign bus.count   = count_reg;
  assign bus.running = running_reg;
  assign bus.last    = (count_reg == LAST_IDX);
  assign bus.wrap    = wrap_reg;

`ifdef SEQ_STEP_COUNTER_ERR_EN
  logic err_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_reg <= 1'b0;
    end else if (bus.clr) begin
      err_reg <= 1'b0;
    end else if ((bus.load && !load_in_range) || !$onehot(t_dec)) begin
      err_reg <= 1'b1;
    end
  end

  assign bus.err = err_reg;
`endif

endmodule

// File: tb/tb_seq_step_counter.sv
// Testbench for seq_step_counter: three instances (16-step wrap, 5-step
// saturate, 6-step wrap). Stimulus pushes the expected post-edge state into a
// queue; a monitor pops one entry per clocked transaction and compares.
module tb_seq_step_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b0;
  logic rst_b = 1'b0;
  logic rst_c = 1'b0;

  seq_step_counter_if #(.NUM_STEPS(16)) ifa ();
  seq_step_counter_if #(.NUM_STEPS(5))  ifb ();
  seq_step_counter_if #(.NUM_STEPS(6))  ifc ();

  seq_step_counter #(.NUM_STEPS(16), .WRAP_MODE(1), .START_RUNNING(1)) dut_a (
    .clk(clk), .rst_n(rst_a), .bus(ifa));
  seq_step_counter #(.NUM_STEPS(5),  .WRAP_MODE(0), .START_RUNNING(1)) dut_b (
    .clk(clk), .rst_n(rst_b), .bus(ifb));
  seq_step_counter #(.NUM_STEPS(6),  .WRAP_MODE(1), .START_RUNNING(1)) dut_c (
    .clk(clk), .rst_n(rst_c), .bus(ifc));

  typedef struct {
    int    id;
    int    cnt;
    bit    run;
    bit    wr;
    bit    er;
    string tag;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic int steps_of(input int id);
    return (id == 0) ? 16 : (id == 1) ? 5 : 6;
  endfunction

  task automatic chk(input string tag, input string fld, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s.%s: got 0x%0h expected 0x%0h", tag, fld, act, exp);
    end
  endtask

  // One clocked transaction: drive at negedge, queue the expected state.
  task automatic cyc(input int id, input bit rn, input bit clr, input bit inc,
                     input bit ld, input int lv, input bit st, input bit sp,
                     input int ecnt, input bit erun, input bit ewr, input bit eerr,
                     input string tag);
    exp_t e;
    @(negedge clk);
    case (id)
      0: begin
        rst_a = rn; ifa.clr = clr; ifa.inc = inc; ifa.load = ld;
        ifa.load_val = 4'(lv); ifa.start = st; ifa.stop = sp;
      end
      1: begin
        rst_b = rn; ifb.clr = clr; ifb.inc = inc; ifb.load = ld;
        ifb.load_val = 3'(lv); ifb.start = st; ifb.stop = sp;
      end
      default: begin
        rst_c = rn; ifc.clr = clr; ifc.inc = inc; ifc.load = ld;
        ifc.load_val = 3'(lv); ifc.start = st; ifc.stop = sp;
      end
    endcase
    e.id = id; e.cnt = ecnt; e.run = erun; e.wr = ewr; e.er = eerr; e.tag = tag;
    q.push_back(e);
  endtask

  // Monitor: one entry per clocked transaction, sampled 1 ns after the edge.
  initial begin
    exp_t   e;
    int     a_cnt;
    longint a_t;
    bit     a_run, a_last, a_wr, a_er;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        a_er = 1'b0;
        case (e.id)
          0: begin
            a_cnt = int'(ifa.count); a_t = 64'(ifa.t); a_run = ifa.running;
            a_last = ifa.last; a_wr = ifa.wrap;
`ifdef SEQ_STEP_COUNTER_ERR_EN
            a_er = ifa.err;
`endif
          end
          1: begin
            a_cnt = int'(ifb.count); a_t = 64'(ifb.t); a_run = ifb.running;
            a_last = ifb.last; a_wr = ifb.wrap;
`ifdef SEQ_STEP_COUNTER_ERR_EN
            a_er = ifb.err;
`endif
          end
          default: begin
            a_cnt = int'(ifc.count); a_t = 64'(ifc.t); a_run = ifc.running;
            a_last = ifc.last; a_wr = ifc.wrap;
`ifdef SEQ_STEP_COUNTER_ERR_EN
            a_er = ifc.err;
`endif
          end
        endcase
        chk(e.tag, "count",   a_cnt, e.cnt);
        chk(e.tag, "t",       a_t, 64'(1) << e.cnt);
        chk(e.tag, "last",    a_last, (e.cnt == steps_of(e.id) - 1));
        chk(e.tag, "running", a_run, e.run);
        chk(e.tag, "wrap",    a_wr, e.wr);
`ifdef SEQ_STEP_COUNTER_ERR_EN
        chk(e.tag, "err",     a_er, e.er);
`endif
        $display("txn %s dut=%0d count=%0d t=0x%0h run=%0b last=%0b wrap=%0b err=%0b",
                 e.tag, e.id, a_cnt, a_t, a_run, a_last, a_wr, a_er);
      end
    end
  end

`ifdef SEQ_STEP_COUNTER_ERR_EN
  always @(negedge clk) begin
    if (rst_a) assert ($onehot(ifa.t)) else $error("FAIL onehot dut_a t=0x%0h", ifa.t);
    if (rst_b) assert ($onehot(ifb.t)) else $error("FAIL onehot dut_b t=0x%0h", ifb.t);
    if (rst_c) assert ($onehot(ifc.t)) else $error("FAIL onehot dut_c t=0x%0h", ifc.t);
  end
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ifa.clr = 0; ifa.inc = 0; ifa.load = 0; ifa.load_val = '0; ifa.start = 0; ifa.stop = 0;
    ifb.clr = 0; ifb.inc = 0; ifb.load = 0; ifb.load_val = '0; ifb.start = 0; ifb.stop = 0;
    ifc.clr = 0; ifc.inc = 0; ifc.load = 0; ifc.load_val = '0; ifc.start = 0; ifc.stop = 0;

    // 16 steps, wrap: full cycle 0..15,0 with a single wrap pulse on the rollover.
    cyc(0, 0,0,0,0,0,0,0, 0,1,0,0, "a_reset");
    for (int k = 1; k <= 17; k++)
      cyc(0, 1,0,1,0,0,0,0, k % 16, 1, (k == 16), 0, "a_wrap");
    cyc(0, 1,0,0,0,0,0,0, 1,1,0,0, "a_hold");

    // Stop+start together at count 2: coincident inc applies, then halted.
    cyc(0, 1,0,0,1,2,0,0, 2,1,0,0, "a_load2");
    cyc(0, 1,0,1,0,0,1,1, 3,0,0,0, "a_stopstart");
    cyc(0, 1,0,1,0,0,0,0, 3,0,0,0, "a_halt_inc1");
    cyc(0, 1,0,1,0,0,0,0, 3,0,0,0, "a_halt_inc2");
    cyc(0, 1,0,1,0,0,1,1, 3,0,0,0, "a_halt_startstop");
    cyc(0, 1,0,1,0,0,1,0, 3,1,0,0, "a_start");
    cyc(0, 1,0,1,0,0,0,0, 4,1,0,0, "a_resume");

    // Priority: clr over load over inc; clr/load suppress wrap at the last step.
    cyc(0, 1,0,0,1,9,0,0, 9,1,0,0, "a_load9");
    cyc(0, 1,1,1,1,5,0,0, 0,1,0,0, "a_clr_pri");
    cyc(0, 1,0,0,1,9,0,0, 9,1,0,0, "a_load9b");
    cyc(0, 1,0,1,1,5,0,0, 5,1,0,0, "a_load_pri");
    cyc(0, 1,0,0,1,15,0,0, 15,1,0,0, "a_load15");
    cyc(0, 1,1,1,0,0,0,0, 0,1,0,0, "a_clr_at_last");
    cyc(0, 1,0,0,1,15,0,0, 15,1,0,0, "a_load15b");
    cyc(0, 1,0,1,1,15,0,0, 15,1,0,0, "a_load_at_last");

    // Mid-run reset from count 7 while halted.
    cyc(0, 1,1,0,0,0,0,0, 0,1,0,0, "a_clr");
    for (int k = 1; k <= 7; k++)
      cyc(0, 1,0,1,0,0,0,0, k,1,0,0, "a_run7");
    cyc(0, 1,0,0,0,0,0,1, 7,0,0,0, "a_stop7");
    cyc(0, 0,0,1,0,0,0,0, 0,1,0,0, "a_midreset");
    cyc(0, 1,0,0,0,0,0,0, 0,1,0,0, "a_after_reset");

    // 5 steps, saturate: park at 4, wrap pulses on the first saturating inc only.
    cyc(1, 0,0,0,0,0,0,0, 0,1,0,0, "b_reset");
    for (int k = 1; k <= 7; k++)
      cyc(1, 1,0,1,0,0,0,0, (k < 4) ? k : 4, 1, (k == 5), 0, "b_sat");
    cyc(1, 1,0,0,1,6,0,0, 4,1,0,1, "b_load_oor");
    cyc(1, 1,0,1,0,0,0,0, 4,1,0,1, "b_sat_again");
    cyc(1, 1,1,0,0,0,0,0, 0,1,0,0, "b_clr");

    // 6 steps (non power of two), wrap: out-of-range load ignored.
    cyc(2, 0,0,0,0,0,0,0, 0,1,0,0, "c_reset");
    cyc(2, 1,0,0,1,3,0,0, 3,1,0,0, "c_load3");
    cyc(2, 1,0,0,1,7,0,0, 3,1,0,1, "c_load7");
    cyc(2, 1,0,1,0,0,0,0, 4,1,0,1, "c_inc4");
    cyc(2, 1,0,1,0,0,0,0, 5,1,0,1, "c_inc5");
    cyc(2, 1,0,1,0,0,0,0, 0,1,1,1, "c_wrap");
    cyc(2, 1,0,1,0,0,0,0, 1,1,0,1, "c_inc1");
    cyc(2, 1,1,0,0,0,0,0, 0,1,0,0, "c_clr");

    @(negedge clk);
    ifc.inc = 0; ifc.clr = 0;
    repeat (3) @(posedge clk);
    #2;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending entries expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
